dwa_element_selector: RTL
=========================

Name: dwa_element_selector

Overview:
- Downstream stage of the second-order notch noise-shaping filter in the DEM-DAC path.
- Takes each signed filter output sample, quantizes and saturates it to a unit-element level count (0..N_ELEM), and selects that many DAC unit elements.
- Selection uses data-weighted averaging (DWA): a rotating pointer spreads element mismatch so mismatch error is first-order shaped.
- Valid/ready handshake on both sides; 2-stage pipeline.

Parameters:
- WIDTH, 16, bit width of input sample (signed two's complement).
- N_ELEM, 16, number of DAC unit elements; power of two, 4..64.
- SHIFT, 12, arithmetic right shift applied before level offset.
- LVL_W, $clog2(N_ELEM+1), width of level count (derived, localparam).
- PTR_W, $clog2(N_ELEM), width of rotation pointer (derived, localparam).

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- reset_ni  in  1  asynchronous, active-low reset.
- data_i  in  WIDTH  signed filter output sample.
- valid_i  in  1  data_i valid.
- ready_o  out  1  block accepts data_i this cycle.
- dwa_en_i  in  1  1 = DWA rotation; 0 = fixed thermometer (pointer forced to 0).
- mask_o  out  N_ELEM  unit-element enable vector, bit k drives element k.
- level_o  out  LVL_W  number of set bits in mask_o.
- ptr_o  out  PTR_W  pointer value used to build mask_o (start index).
- sat_o  out  1  sample was clamped during quantization.
- valid_o  out  1  mask_o/level_o/ptr_o/sat_o valid.
- ready_i  in  1  downstream accepts output this cycle.

Behaviour:
- Reset (reset_ni=0, asynchronous): mask_o=0, level_o=0, ptr_o=0, sat_o=0, valid_o=0, internal pointer=0, stage-1 valid=0. ready_o=1 from the first edge after release.
- Stage 1 (quantize): q = (data_i >>> SHIFT) + N_ELEM/2, computed signed at WIDTH+1 bits.
  - q<0 -> level=0, sat=1.
  - q>N_ELEM -> level=N_ELEM, sat=1.
  - Otherwise level=q, sat=0.
- Stage 2 (rotate):
  - mask bit k = 1 iff ((k - ptr) mod N_ELEM) < level.
  - On transfer out of stage 2: ptr_next = (ptr + level) mod N_ELEM.
  - level=N_ELEM -> mask all ones, ptr unchanged.
  - level=0 -> mask zero, ptr unchanged.
  - ptr_o reports the pre-update pointer.
- dwa_en_i=0:
  - Pointer used for the mask = 0 and stored pointer cleared to 0.
  - Sampled in stage 2 at the stage-2 load cycle.
- Handshake:
  - Input transfer when valid_i & ready_o.
  - Output transfer when valid_o & ready_i.
  - advance = !valid_o | ready_i.
  - ready_o = !s1_valid | advance.
  - Stage 2 loads from stage 1 when advance.
  - Latency: accepted sample appears on valid_o 2 cycles after acceptance when not stalled.
  - Throughput: 1 sample/cycle.
  - No drops or duplicates under any ready_i pattern.
- Stall: while valid_o & !ready_i, all outputs and the pointer hold stable. valid_o never deasserts without a transfer.
- Pointer wrap: arithmetic is mod N_ELEM. ptr + level ≥ N_ELEM wraps, and the mask wraps around from bit N_ELEM-1 to bit 0.
- Simultaneous input transfer and output transfer in the same cycle: both occur, pipeline stays full.
- Reset mid-stream: in-flight samples are discarded and the pointer returns to 0.

Decomposition:
- Package dem_pkg:
  - N_ELEM and SHIFT defaults.
  - level_t and ptr_t typedefs.
  - Function thermo_rotate(level, ptr) returning the mask.
  - Shared with the future element-mismatch model and the DAC driver.
- Sub-module dem_quantizer: combinational shift/offset/saturate returning level and sat. Stage registers live in dwa_element_selector.

Test Plan:
- Reset then data_i=0, dwa_en_i=1, ready_i=1:
  - Result: level_o=8, ptr_o=0, mask_o=0x00FF, sat_o=0, valid_o rising 2 cycles after accept.
  - Next data_i=0 -> ptr_o=8, mask_o=0xFF00.
- Wrap: drive data_i=-8192 (level 6) three times:
  - ptr_o sequence 0, 6, 12.
  - Third mask_o=0xF003 (wraps across bit 15 to bit 0).
  - Stored pointer afterwards = 2.
- Saturation:
  - data_i=32767 -> level_o=15, sat_o=0.
  - SHIFT=11 instance with data_i=32767 -> level_o=16, mask_o=0xFFFF, sat_o=1, pointer unchanged.
  - SHIFT=11 instance with data_i=-32768 -> level_o=0, mask_o=0, sat_o=1.
- Backpressure:
  - Stream 10 samples with ready_i toggling pseudo-randomly.
  - Outputs stay stable while stalled; exactly 10 transfers in order.
  - Pointer equals the reference model's cumulative level sum mod 16.
- dwa_en_i=0 with data_i=-4096 (level 7) repeated: mask_o=0x007F and ptr_o=0 every sample.
- Assert reset_ni low for 1 cycle mid-stream with the pipeline full:
  - valid_o=0 and mask_o=0 immediately (asynchronous).
  - The first post-reset sample uses ptr_o=0.

Source files
------------

// File: rtl/dem_pkg.sv
// Shared DEM-DAC definitions: default geometry, level/pointer types, rotation mask helper.
// Latency: n/a (types and a combinational function only).
// Backpressure: n/a.
package dem_pkg;

    // Default element count and pre-offset shift for the DWA selector.
    localparam int DEF_N_ELEM = 16;
    localparam int DEF_SHIFT  = 12;

    // Largest element array any consumer of this package supports.
    // Types are sized for it so the element-mismatch model, the DAC driver
    // and the selector share one definition regardless of their N_ELEM.
    localparam int MAX_ELEM = 64;

    typedef logic [$clog2(MAX_ELEM+1)-1:0] level_t;
    typedef logic [$clog2(MAX_ELEM)-1:0]   ptr_t;
    typedef logic [MAX_ELEM-1:0]           mask_t;

    // Rotated thermometer: bit k is set iff ((k - ptr) mod n_elem) < level.
    // n_elem must be a power of two so the modulo reduces to a bit mask.
    // Bits at or above n_elem are always zero.
    function automatic mask_t thermo_rotate(input level_t level,
                                            input ptr_t   ptr,
                                            input int     n_elem);
        mask_t m;
        ptr_t  wrap;
        ptr_t  off;
        m    = '0;
        wrap = ptr_t'(n_elem - 1);
        for (int k = 0; k < MAX_ELEM; k++) begin
            off  = (ptr_t'(k) - ptr) & wrap;
            m[k] = (k < n_elem) && ({1'b0, off} < level);
        end
        return m;
    endfunction

endpackage

// File: rtl/dem_quantizer.sv
// Quantizes a signed filter sample to a unit-element level: shift, re-centre, saturate.
// Latency: combinational (0 cycles); the caller registers the result.
// Backpressure: none; pure function of data.
module dem_quantizer
    import dem_pkg::*;
#(
    parameter  int WIDTH  = 16,
    parameter  int N_ELEM = DEF_N_ELEM,
    parameter  int SHIFT  = DEF_SHIFT,
    localparam int LVL_W  = $clog2(N_ELEM + 1)
) (
    input  logic signed [WIDTH-1:0] data,
    output logic        [LVL_W-1:0] level,
    output logic                    sat
);

    // One extra bit of headroom so the offset add never overflows.
    localparam logic signed [WIDTH:0] HALF  = (WIDTH+1)'(N_ELEM / 2);
    localparam logic signed [WIDTH:0] MAX_Q = (WIDTH+1)'(N_ELEM);

    logic signed [WIDTH:0] ext;
    logic signed [WIDTH:0] shifted;
    logic signed [WIDTH:0] q;

    assign ext     = {data[WIDTH-1], data};
    assign shifted = ext >>> SHIFT;
    assign q       = shifted + HALF;

    // Clamp the re-centred sample into 0..N_ELEM and flag any clamping.
    always_comb begin
        level = '0;
        sat   = 1'b0;
        if (q[WIDTH]) begin
            level = '0;
            sat   = 1'b1;
        end else if (q > MAX_Q) begin
            level = LVL_W'(N_ELEM);
            sat   = 1'b1;
        end else begin
            level = q[LVL_W-1:0];
        end
    end

endmodule

// File: rtl/dwa_element_selector.sv
// DWA unit-element selector: quantize sample to a level, then pick that many elements from a rotating pointer.
// Latency: 2 cycles from input acceptance to valid_o; 1 sample/cycle throughput.
// Backpressure: full valid/ready; outputs and pointer hold while valid_o & !ready_i, ready_o drops only when both stages are full and stalled.
module dwa_element_selector
    import dem_pkg::*;
#(
    parameter  int WIDTH  = 16,
    parameter  int N_ELEM = DEF_N_ELEM,
    parameter  int SHIFT  = DEF_SHIFT,
    localparam int LVL_W  = $clog2(N_ELEM + 1),
    localparam int PTR_W  = $clog2(N_ELEM)
) (
    input  logic                    clk_i,
    input  logic                    reset_ni,
    input  logic signed [WIDTH-1:0] data_i,
    input  logic                    valid_i,
    output logic                    ready_o,
    input  logic                    dwa_en_i,
    output logic       [N_ELEM-1:0] mask_o,
    output logic        [LVL_W-1:0] level_o,
    output logic        [PTR_W-1:0] ptr_o,
    output logic                    sat_o,
    output logic                    valid_o,
    input  logic                    ready_i
);

    // ------------------------------------------------------------------
    // Stage 1: quantize
    // ------------------------------------------------------------------
    logic [LVL_W-1:0] q_level;
    logic             q_sat;

    logic             s1_valid;
    logic [LVL_W-1:0] s1_level;
    logic             s1_sat;

    dem_quantizer #(
        .WIDTH  (WIDTH),
        .N_ELEM (N_ELEM),
        .SHIFT  (SHIFT)
    ) u_quant (
        .data  (data_i),
        .level (q_level),
        .sat   (q_sat)
    );

    // Stage 2 can take a new sample when it is empty or its content leaves now.
    logic advance;
    assign advance = !valid_o || ready_i;

    // Stage 1 refills whenever it is empty or draining into stage 2.
    assign ready_o = !s1_valid || advance;

    // Capture the quantized sample on input transfer; bubble when nothing arrives.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            s1_valid <= 1'b0;
            s1_level <= '0;
            s1_sat   <= 1'b0;
        end else if (ready_o) begin
            s1_valid <= valid_i;
            if (valid_i) begin
                s1_level <= q_level;
                s1_sat   <= q_sat;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: rotate
    // ------------------------------------------------------------------
    // ptr_q is the start index for the next sample entering stage 2. Because
    // stage 2 only loads once the previous sample has left, advancing it at
    // load time is the same as advancing it on output transfer.
    logic [PTR_W-1:0] ptr_q;
    logic [PTR_W-1:0] ptr_use;
    logic [LVL_W-1:0] ptr_sum;
    mask_t            mask_full;
    logic [N_ELEM-1:0] mask_nxt;

    // Fixed-thermometer mode anchors every sample at element 0.
    assign ptr_use   = dwa_en_i ? ptr_q : '0;

    // LVL_W is one bit wider than PTR_W, so the carry is simply dropped for mod N.
    assign ptr_sum   = LVL_W'(ptr_use) + s1_level;

    assign mask_full = thermo_rotate(level_t'(s1_level), ptr_t'(ptr_use), N_ELEM);
    assign mask_nxt  = mask_full[N_ELEM-1:0];

    if (N_ELEM < MAX_ELEM) begin : g_mask_hi
        // Upper bits of the shared-width mask are always zero here.
        logic unused_mask_hi;
        assign unused_mask_hi = ^mask_full[MAX_ELEM-1:N_ELEM];
    end

    // Load the output register and step the pointer when stage 2 advances.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            valid_o <= 1'b0;
            mask_o  <= '0;
            level_o <= '0;
            ptr_o   <= '0;
            sat_o   <= 1'b0;
            ptr_q   <= '0;
        end else if (advance) begin
            valid_o <= s1_valid;
            if (s1_valid) begin
                mask_o  <= mask_nxt;
                level_o <= s1_level;
                ptr_o   <= ptr_use;
                sat_o   <= s1_sat;
                // Thermometer mode leaves the rotation restarting at 0.
                ptr_q   <= dwa_en_i ? ptr_sum[PTR_W-1:0] : '0;
            end
        end
    end

endmodule
